// File: rtl/mod_step_counter_if.sv
// Bus bundle for mod_step_counter.
//   master : drives the controls (clear, load, load_val, en, dir, step, sat)
//            and observes the count and flags.
//   slave  : the counter; samples the controls and drives out, at_max, at_min,
//            bound and sticky.
// Clock and reset are not part of the bundle; they stay scalar module ports.
interface mod_step_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             dir;
  logic [WIDTH-1:0] step;
  logic             sat;
  logic [WIDTH-1:0] out;
  logic             at_max;
  logic             at_min;
  logic             bound;
  logic             sticky;

  modport master (
    output clear, load, load_val, en, dir, step, sat,
    input  out, at_max, at_min, bound, sticky
  );

  modport slave (
    input  clear, load, load_val, en, dir, step, sat,
    output out, at_max, at_min, bound, sticky
  );
endinterface

// File: rtl/mod_step_counter.sv
// Programmable-modulus up/down counter with variable step.
// Counts modulo MAX+1 (wrap) or clips at 0/MAX (saturate). A registered one-cycle
// pulse (bound) marks every update that crossed or clipped at a boundary, and a
// sticky flag latches any such event until clear or reset.
// Ports:
//   clk_i     system clock, all state changes on posedge
//   reset_ni  asynchronous active-low reset: count and flags cleared while low
//   bus_if    slave side of mod_step_counter_if:
//               clear/load/load_val/en/dir/step/sat in,
//               out (registered count), at_max/at_min (decoded from out),
//               bound (event pulse), sticky (latched event) out
module mod_step_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = 2**WIDTH - 1
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  mod_step_counter_if.slave   bus_if
);

  localparam int unsigned      ExtW   = WIDTH + 1;
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);
  localparam logic [WIDTH:0]   MaxExt = ExtW'(MAX);
  localparam logic [WIDTH:0]   ModExt = ExtW'(MAX + 1);

  logic [WIDTH-1:0] out_q, out_d;
  logic             bound_q, bound_d;
  logic             sticky_q, sticky_d;

  logic [WIDTH-1:0] step_eff;
  logic [WIDTH-1:0] load_eff;
  logic [WIDTH:0]   cur_ext;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH-1:0] up_wrap;
  logic [WIDTH-1:0] dn_diff;
  logic [WIDTH-1:0] dn_wrap;
  logic             up_cross;
  logic             dn_cross;

  // Datapath: one extra bit of headroom so out+s never truncates before the
  // boundary compare.
  always_comb begin
    step_eff = (bus_if.step > MaxVal) ? MaxVal : bus_if.step;
    load_eff = (bus_if.load_val > MaxVal) ? MaxVal : bus_if.load_val;
    cur_ext  = {1'b0, out_q};
    step_ext = {1'b0, step_eff};
    up_sum   = cur_ext + step_ext;
    up_cross = (up_sum > MaxExt);
    // out + s - (MAX+1) < MAX+1 whenever up_cross holds, so it fits WIDTH bits.
    up_wrap  = WIDTH'(up_sum - ModExt);
    dn_cross = (step_ext > cur_ext);
    dn_diff  = WIDTH'(cur_ext - step_ext);
    // out + (MAX+1) - s lies in [0, MAX] whenever dn_cross holds.
    dn_wrap  = WIDTH'(cur_ext + ModExt - step_ext);
  end

  // Next state: clear > load > en > hold. bound defaults low so it only
  // survives one cycle unless the next update is also a boundary event.
  always_comb begin
    out_d    = out_q;
    bound_d  = 1'b0;
    sticky_d = sticky_q;
    if (bus_if.clear) begin
      out_d    = '0;
      sticky_d = 1'b0;
    end else if (bus_if.load) begin
      out_d = load_eff;
    end else if (bus_if.en && (step_eff != '0)) begin
      if (bus_if.dir) begin
        if (up_cross) begin
          out_d    = bus_if.sat ? MaxVal : up_wrap;
          bound_d  = 1'b1;
          sticky_d = 1'b1;
        end else begin
          out_d = WIDTH'(up_sum);
        end
      end else begin
        if (dn_cross) begin
          out_d    = bus_if.sat ? '0 : dn_wrap;
          bound_d  = 1'b1;
          sticky_d = 1'b1;
        end else begin
          out_d = dn_diff;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      out_q    <= '0;
      bound_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      bound_q  <= bound_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus_if.out    = out_q;
  assign bus_if.at_max = (out_q == MaxVal);
  assign bus_if.at_min = (out_q == '0);
  assign bus_if.bound  = bound_q;
  assign bus_if.sticky = sticky_q;

endmodule

// File: doc/mod_step_counter.md
Name: mod_step_counter

Overview:
- Parametrised successor to the single-step up-counter used for FIFO read/write pointers and general event counting.
- Adds a programmable modulus, up/down direction, variable step, a wrap-or-saturate mode, synchronous load/clear, and registered boundary-event flags.
- Serves as the common pointer/occupancy/timer counter for the FIFO/RAM blocks and for later datapath control.

Parameters:
- WIDTH, 4, bit width of the count, load value and step.
- MAX, 2**WIDTH-1, top count value (modulus = MAX+1); legal range 1..2**WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (count and flags cleared while low).
- clear  input  1  synchronous clear of count and sticky flag.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value loaded when load=1.
- en  input  1  count enable.
- dir  input  1  1 = count up, 0 = count down.
- step  input  WIDTH  increment/decrement amount per enabled cycle.
- sat  input  1  0 = wrap modulo MAX+1, 1 = saturate at 0/MAX.
- out  output  WIDTH  current count, registered.
- at_max  output  1  combinational, out == MAX.
- at_min  output  1  combinational, out == 0.
- bound  output  1  registered one-cycle pulse: last update crossed a boundary (wrapped or clipped).
- sticky  output  1  registered; set by any boundary event, held until clear or reset.

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-count): out=0, bound=0, sticky=0. at_max=0 and at_min=1 follow from out.
- First update occurs on the first posedge after reset deasserts.
- Priority per posedge, highest first: clear, then load, then en, otherwise hold.
  - clear=1: out<=0, bound<=0, sticky<=0.
  - load=1: out<=min(load_val, MAX), bound<=0, sticky unchanged.
  - en=1: out updates by effective step s (see below).
  - No operation selected: out holds, bound<=0.
- Effective step: s = min(step, MAX). If s=0 with en=1, out holds and bound<=0.
- Arithmetic uses WIDTH+1 bits internally; there is no silent truncation.
- Up, no boundary: if out+s <= MAX, out<=out+s and bound<=0.
- Up, crossing MAX:
  - sat=0: out<=out+s-(MAX+1).
  - sat=1: out<=MAX.
  - In both cases bound<=1 and sticky<=1.
- Up, sat=1 with out already at MAX: out holds MAX, bound<=1 (clip event).
- Down, no boundary: if s <= out, out<=out-s and bound<=0.
- Down, crossing 0:
  - sat=0: out<=out+(MAX+1)-s.
  - sat=1: out<=0.
  - In both cases bound<=1 and sticky<=1.
- Landing exactly on MAX (up) or 0 (down) is not a boundary event.
- Latency:
  - out, bound and sticky reflect an operation one cycle after the posedge that samples it.
  - at_max/at_min are valid in the same cycle as out.
- bound is high for exactly one cycle per event. Back-to-back events keep it high on consecutive cycles.
- dir, step and sat are sampled only when en=1 and neither clear nor load is active. Changing them mid-count takes effect on the next enabled edge.
- With defaults (MAX=2**WIDTH-1, step=1, dir=1, sat=0), behaviour matches the legacy single-step counter, with the addition of bound/sticky.

Test Plan:
- Reset mid-count: WIDTH=4, MAX=9; count up to 6, pull reset low between edges -> out=0, sticky=0 immediately without a clock edge; counting resumes 1,2,... after release.
- Wrap up: MAX=9, step=1, dir=1, sat=0, from 0 for 12 edges -> out 1..9,0,1,2; bound high only on the cycle out=0; sticky=1 thereafter.
- Saturate down, variable step: MAX=9, load 5, dir=0, step=3, sat=1 -> out 2, then 0 with bound=1, then holds 0 with bound=1 each edge; at_min=1.
- Wrap down with step: MAX=9, load 1, dir=0, step=4, sat=0 -> out=7, bound=1; next edge out=3, bound=0.
- Clamping and priority: MAX=9; load_val=14 -> out=9, at_max=1; assert clear+load+en together -> out=0, sticky=0; step=15 with dir=1, sat=0 from 0 -> s=9, out=9, bound=0.
- Hold cases: en=0 for 5 edges, or en=1 with step=0 -> out unchanged, bound=0, sticky unchanged.
